// File: rtl/axis_1553_pkg.sv
// rtl/axis_1553_pkg.sv - shared state, tuser and command-word definitions for the 1553 BC scheduler
package axis_1553_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN,
    ST_GAP
  } bc_state_e;

  localparam logic [7:0] TUSER_CMD_SYNC  = 8'h80;
  localparam logic [7:0] TUSER_DATA_SYNC = 8'h40;

  localparam int CMD_TR_BIT = 10;
  localparam int CMD_SA_LSB = 5;
  localparam int CMD_SA_W   = 5;
  localparam int CMD_WC_LSB = 0;
  localparam int CMD_WC_W   = 5;

  // Number of data words the BC must send after this command word.
  function automatic logic [5:0] cmd_data_count(input logic [15:0] cmd);
    logic [4:0] sa;
    logic [4:0] wc;
    sa = cmd[CMD_SA_LSB +: CMD_SA_W];
    wc = cmd[CMD_WC_LSB +: CMD_WC_W];
    if (cmd[CMD_TR_BIT]) return 6'd0;
    if (sa == 5'd0 || sa == 5'd31) return {5'd0, wc[4]};
    return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
  endfunction

endpackage

// File: rtl/bc_rr_arbiter.sv
// rtl/bc_rr_arbiter.sv - 2-way round-robin arbiter; the requester not granted last wins a tie
module bc_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (update && gnt != 2'b00) last_d = gnt[1];
  end

  // Reset as if requester 1 was served last so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/axis_1553_bc_scheduler.sv
// rtl/axis_1553_bc_scheduler.sv - 1553 bus-controller message scheduler for two requesters
// BC_GAP_TIMER_EN: GAP lasts (clock_speed/1e6)*gap_us cycles instead of a single cycle.
module axis_1553_bc_scheduler
  import axis_1553_pkg::*;
#(
  parameter int clock_speed = 20000000,
  parameter int gap_us      = 4
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [31:0] s_cmd_tdata,
  input  logic [1:0]  s_cmd_tvalid,
  output logic [1:0]  s_cmd_tready,
  input  logic [31:0] s_dat_tdata,
  input  logic [1:0]  s_dat_tvalid,
  output logic [1:0]  s_dat_tready,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        en_diff,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int GAP_TIMER = (clock_speed / 1000000) * gap_us;
`ifdef BC_GAP_TIMER_EN
  localparam int GAP_CYCLES = (GAP_TIMER > 1) ? GAP_TIMER : 1;
`else
  localparam int GAP_CYCLES = 1;
`endif
  localparam int GAP_W = $clog2(GAP_TIMER + 2);

  bc_state_e        state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic        sel;
  logic [15:0] cmd_word;
  logic [15:0] dat_word;
  logic        dat_valid;
  logic [1:0]  arb_gnt;
  logic        arb_update;

  assign sel       = grant_q[1];
  assign cmd_word  = sel ? s_cmd_tdata[31:16] : s_cmd_tdata[15:0];
  assign dat_word  = sel ? s_dat_tdata[31:16] : s_dat_tdata[15:0];
  assign dat_valid = sel ? s_dat_tvalid[1]    : s_dat_tvalid[0];

  bc_rr_arbiter u_arb (
    .clk    (aclk),
    .rst    (arst),
    .req    (s_cmd_tvalid),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    arb_update    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 16'h0000;
    m_axis_tuser  = 8'h00;
    s_cmd_tready  = 2'b00;
    s_dat_tready  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|s_cmd_tvalid) begin
          state_d    = ST_CMD;
          grant_d    = arb_gnt;
          arb_update = 1'b1;
        end
      end
      ST_CMD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = cmd_word;
        m_axis_tuser  = TUSER_CMD_SYNC;
        s_cmd_tready  = grant_q & {2{m_axis_tready}};
        if (m_axis_tready) begin
          cnt_d   = cmd_data_count(cmd_word);
          state_d = (cnt_d == 6'd0) ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        m_axis_tvalid = dat_valid;
        if (dat_valid) begin
          m_axis_tdata = dat_word;
          m_axis_tuser = TUSER_DATA_SYNC;
        end
        s_dat_tready = grant_q & {2{m_axis_tready}};
        if (dat_valid && m_axis_tready) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Wait for the encoder to release the line before timing the gap.
        if (!en_diff) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      cnt_q   <= 6'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/axis_1553_bc_scheduler.md
AXIS_1553_BC_SCHEDULER -- requirements
Module: axis_1553_bc_scheduler

Interface
REQ-001 Parameter clock_speed, default 20000000, aclk frequency in Hz.
REQ-002 Parameter gap_us, default 4, minimum inter-message gap in microseconds.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 arst  input  1  reset; asynchronous, active-high.
REQ-005 s_cmd_tdata  input  32  command words, requester r at bits [16r+15:16r], r = 0..1.
REQ-006 s_cmd_tvalid / s_cmd_tready  input / output  2  per-requester command handshake.
REQ-007 s_dat_tdata  input  32  data words, same packing as s_cmd_tdata.
REQ-008 s_dat_tvalid / s_dat_tready  input / output  2  per-requester data handshake.
REQ-009 m_axis_tdata  output  16  word to the 1553 encoder.
REQ-010 m_axis_tuser  output  8  word type: 8'h80 = command sync, 8'h40 = data sync.
REQ-011 m_axis_tvalid / m_axis_tready  output / input  1  encoder handshake.
REQ-012 en_diff  input  1  encoder line-driver enable, high while a word is on the bus.
REQ-013 grant  output  2  one-hot owner of the current message, 0 when idle.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, CMD, DATA, DRAIN, GAP.
- IDLE -> CMD when any s_cmd_tvalid is high; the winner is registered into grant on that edge.
REQ-016 Arbitration is round-robin.
- On simultaneous requests, the requester not granted last wins.
- A lone requester always wins.
REQ-017 CMD state: m_axis_tdata = command word of the granted requester, m_axis_tuser = 8'h80, m_axis_tvalid = 1.
- s_cmd_tready[g] = m_axis_tready, so the command is popped on the same cycle the encoder accepts it.
REQ-018 Data count N is derived from the command word:
- Command bit10 = 1 (transmit): N = 0.
- Subaddress (bits 9:5) = 0 or 31 (mode code): N = 1 if bit4 = 1 and bit10 = 0, otherwise N = 0.
- All other cases: N = bits 4:0, and a value of 0 means 32.
REQ-019 CMD exits on the command handshake: to DATA if N > 0, otherwise to DRAIN.
REQ-020 DATA state is a combinational pass-through of the granted requester:
- m_axis_tdata = s_dat_tdata[g], m_axis_tvalid = s_dat_tvalid[g], s_dat_tready[g] = m_axis_tready, m_axis_tuser = 8'h40.
- A 6-bit counter decrements on each handshake; DATA -> DRAIN on the handshake of word N.
REQ-021 Ungranted requesters see tready = 0 at all times.
REQ-022 A data-side stall is held indefinitely; the block has no timeout.
REQ-023 DRAIN -> GAP on the first cycle with en_diff = 0 and m_axis_tvalid = 0.
REQ-024 GAP counts the configured gap (see Configuration), then goes to IDLE with grant = 0.
- grant is held from CMD through GAP.
REQ-025 m_axis_tvalid = 0 in IDLE, DRAIN and GAP.
- m_axis_tdata/m_axis_tuser are don't-care when m_axis_tvalid = 0, and the bench treats them as 0.
REQ-026 A new arbitration can occur no earlier than the cycle after GAP exits.

Reset
REQ-027 Asserting arst forces the following immediately, including mid-message:
- state = IDLE, grant = 0, busy = 0, all tready = 0, m_axis_tvalid = 0, counters = 0.
- Round-robin pointer set so that requester 0 wins the first tie.
REQ-028 The first arbitration occurs on the first rising edge after arst deasserts on which a request is present.

Configuration
REQ-029 Macro BC_GAP_TIMER_EN selects the GAP behaviour:
- Defined: GAP lasts (clock_speed/1000000)*gap_us cycles, 80 with defaults.
- Undefined: GAP lasts exactly 1 cycle and the gap_us parameter is ignored.

Structure
REQ-030 Shared package axis_1553_pkg holds:
- the FSM state enum;
- the tuser constants TUSER_CMD_SYNC = 8'h80 and TUSER_DATA_SYNC = 8'h40;
- command-word field positions (TR bit 10, SA 9:5, WC 4:0).
REQ-031 One sub-module, bc_rr_arbiter: 2-way round-robin, inputs req[1:0] and update, output one-hot gnt.

Verification
REQ-032 Requester 0 sends receive command 16'h0823 (SA 1, WC 3) with data 16'h1111/2222/3333.
- Required: encoder sees 1 command (tuser 80) then 3 data words (tuser 40); grant = 01 throughout; busy drops 80 cycles after en_diff falls.
REQ-033 Both requesters present commands on the same cycle after reset.
- Required: requester 0 is served first, then requester 1; repeated for 4 messages the grant sequence is 01,10,01,10.
REQ-034 Transmit command 16'h0C20 from requester 1.
- Required: one word only; s_dat_tready stays 0.
REQ-035 Command 16'h0820 (WC 0).
- Required: exactly 32 data words are forwarded; an s_dat_tvalid stall of 10 cycles mid-stream stretches DATA with no word lost.
REQ-036 Mode command 16'h0011 (SA 0, code 17).
- Required: 1 data word follows; mode command 16'h0002 forwards 0 data words.
REQ-037 Reset asserted during DATA word 2 of 5.
- Required: all outputs are at their reset values immediately; after release a fresh command is handled normally.
- Build both with and without BC_GAP_TIMER_EN; the GAP length is 80 and 1 cycles respectively.
